// File: rtl/rr_arb_mux_if.sv
// ----------------------------------------------------------------------------
// rr_arb_mux_if : channel-side and output-side handshake bundle for rr_arb_mux
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int SELW  = $clog2(N)
);
  logic                 mode;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  // Arbiter view
  modport slave (
    input  mode, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );

  // Producer/consumer view
  modport master (
    output mode, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// ----------------------------------------------------------------------------
// rr_arb_mux : N:1 arbitrating mux (fixed priority / round-robin) with burst
//              grant lock and a registered output stage (1-cycle latency)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int SELW  = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb_mux_if.slave bus_if
);

  typedef enum logic [0:0] {
    S_FREE   = 1'b0,
    S_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e      state_q, state_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             w_load;
  logic             w_xfer;
  logic             w_fp_found;
  logic [SELW-1:0]  w_fp_idx;
  logic             w_rr_found;
  logic [SELW-1:0]  w_rr_idx;
  logic [SELW-1:0]  w_cand [N];
  logic             w_gvalid;
  logic [SELW-1:0]  w_grant;
  logic [WIDTH-1:0] w_gdata;
  logic             w_glast;
  logic [SELW-1:0]  w_ptr_inc;

  // out_ready feeds in_ready combinationally so the stage streams 1 beat/cycle
  assign w_load = !out_valid_q || bus_if.out_ready;

  always_comb begin
    w_fp_found = 1'b0;
    w_fp_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus_if.in_valid[i]) begin
        w_fp_found = 1'b1;
        w_fp_idx   = SELW'(i);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (int'(ptr_q) + k >= N) begin
        w_cand[k] = SELW'(int'(ptr_q) + k - N);
      end else begin
        w_cand[k] = SELW'(int'(ptr_q) + k);
      end
    end
  end

  // Scan candidates from the far end so the one closest to ptr wins
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus_if.in_valid[w_cand[k]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand[k];
      end
    end
  end

  always_comb begin
    w_grant  = w_fp_idx;
    w_gvalid = w_fp_found;
    if (state_q == S_LOCKED) begin
      w_grant  = lock_ch_q;
      w_gvalid = bus_if.in_valid[lock_ch_q];
    end else if (bus_if.mode) begin
      w_grant  = w_rr_idx;
      w_gvalid = w_rr_found;
    end
  end

  assign w_xfer  = rst_n && w_load && w_gvalid;
  assign w_glast = bus_if.in_last[w_grant];

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_gdata = bus_if.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus_if.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus_if.in_ready[i] = w_xfer && (w_grant == SELW'(i));
    end
  end

  assign w_ptr_inc = (w_grant == SELW'(N - 1)) ? '0 : w_grant + SELW'(1);

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (w_xfer) begin
      out_data_d  = w_gdata;
      out_sel_d   = w_grant;
      out_last_d  = w_glast;
      out_valid_d = 1'b1;
      if (w_glast) begin
        ptr_d = w_ptr_inc;
      end else begin
        lock_ch_d = w_grant;
      end
    end else if (bus_if.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_FREE:   if (w_xfer && !w_glast) state_d = S_LOCKED;
      S_LOCKED: if (w_xfer && w_glast)  state_d = S_FREE;
      default:  state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FREE;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_sel   = out_sel_q;
  assign bus_if.out_last  = out_last_q;
  assign bus_if.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// ----------------------------------------------------------------------------
// tb_rr_arb_mux : self-checking bench, per-channel beat queues + output scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rr_arb_mux;
  localparam int N = 16;
  localparam int W = 32;

  typedef struct packed { logic [31:0] d; logic l; } beat_t;
  typedef struct packed { logic [3:0] sel; logic [31:0] d; logic l; } exp_t;
  typedef struct { logic mode; logic [15:0] valid; int n; logic [63:0] order; } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(W),  .N(N)) bus ();
  rr_arb_mux_if #(.WIDTH(8),  .N(2)) s2  ();
  rr_arb_mux_if #(.WIDTH(64), .N(5)) s5  ();

  rr_arb_mux #(.WIDTH(W),  .N(N)) u_dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));
  rr_arb_mux #(.WIDTH(8),  .N(2)) u_s2  (.clk(clk), .rst_n(rst_n), .bus_if(s2));
  rr_arb_mux #(.WIDTH(64), .N(5)) u_s5  (.clk(clk), .rst_n(rst_n), .bus_if(s5));

  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  beat_t chq [N][$];
  exp_t  sb [$];
  int    pop_cyc [$];
  logic [N-1:0] acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int ch, input int b);
    return (32'(ch) * 32'h0101_0101) ^ (32'(b) << 28);
  endfunction

  task automatic ld(input int ch, input int b, input logic l);
    chq[ch].push_back('{pat(ch, b), l});
  endtask

  task automatic expb(input int ch, input int b, input logic l);
    sb.push_back('{4'(ch), pat(ch, b), l});
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(input int maxc);
    int c;
    c = 0;
    while (sb.size() != 0 && c < maxc) begin
      step();
      c++;
    end
    chk("drain-timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_contig(input int c0, input int n, input string nm);
    if (pop_cyc.size() >= c0 + n)
      chk(nm, 64'(pop_cyc[c0 + n - 1] - pop_cyc[c0]), 64'(n - 1));
  endtask

  // Channel driver: present queue heads, retire beats accepted on the previous edge
  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst_n) chq[i].delete();
      else if (acc[i] && chq[i].size() != 0) void'(chq[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (chq[i].size() != 0) begin
        bus.in_valid[i]          = 1'b1;
        bus.in_data[i*W +: W]    = chq[i][0].d;
        bus.in_last[i]           = chq[i][0].l;
      end else begin
        bus.in_valid[i]          = 1'b0;
        bus.in_data[i*W +: W]    = '0;
        bus.in_last[i]           = 1'b0;
      end
    end
    #1 acc = bus.in_ready;
  end

  // Output monitor: every beat consumed downstream is checked against the scoreboard
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected-beat: got sel %0d data 0x%0h, expected no beat", bus.out_sel, bus.out_data);
      end else begin
        e = sb.pop_front();
        chk("out_sel", 64'(bus.out_sel), 64'(e.sel));
        chk("out_data", 64'(bus.out_data), 64'(e.d));
        chk("out_last", 64'(bus.out_last), 64'(e.l));
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    logic [63:0] ord;
    logic [31:0] held;
    int c0;
    int s;

    vt[0] = '{1'b0, 16'h8024, 3,  64'h0000_0000_0000_0F52};
    vt[1] = '{1'b1, 16'hFFFF, 16, 64'hFEDC_BA98_7654_3210};
    vt[2] = '{1'b1, 16'h0003, 2,  64'h0000_0000_0000_0010};
    vt[3] = '{1'b1, 16'h0111, 3,  64'h0000_0000_0000_0084};
    vt[4] = '{1'b0, 16'h0111, 3,  64'h0000_0000_0000_0840};
    vt[5] = '{1'b1, 16'h8201, 3,  64'h0000_0000_0000_00F9};
    vt[6] = '{1'b1, 16'hC000, 2,  64'h0000_0000_0000_00FE};

    bus.mode = 1'b0; bus.out_ready = 1'b1;
    s2.mode = 1'b1; s2.out_ready = 1'b1; s2.in_valid = '0; s2.in_last = '0; s2.in_data = '0;
    s5.mode = 1'b1; s5.out_ready = 1'b1; s5.in_valid = '0; s5.in_last = '0; s5.in_data = '0;

    repeat (3) step();
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_data",  64'(bus.out_data),  64'd0);
    chk("rst out_sel",   64'(bus.out_sel),   64'd0);
    chk("rst out_last",  64'(bus.out_last),  64'd0);
    chk("rst in_ready",  64'(bus.in_ready),  64'd0);
    rst_n = 1'b1;
    step();

    // Single-beat scenarios; each expected grant order assumes the ptr left by the previous row
    for (int r = 0; r < 7; r++) begin
      step();
      bus.mode = vt[r].mode;
      for (int ch = 0; ch < N; ch++) if (vt[r].valid[ch]) ld(ch, 0, 1'b1);
      ord = vt[r].order;
      for (int i = 0; i < vt[r].n; i++) begin
        s = int'(ord[i*4 +: 4]);
        expb(s, 0, 1'b1);
      end
      c0 = pop_cyc.size();
      wait_drain(60);
      chk_contig(c0, vt[r].n, "table no-bubble");
    end

    // Burst lock: ch3 holds the grant for 4 beats while ch4 waits
    step();
    bus.mode = 1'b1;
    for (int b = 0; b < 4; b++) ld(3, b, b == 3);
    ld(4, 0, 1'b1);
    for (int b = 0; b < 4; b++) expb(3, b, b == 3);
    expb(4, 0, 1'b1);
    c0 = pop_cyc.size();
    wait_drain(40);
    chk_contig(c0, 5, "burst no-bubble");

    // Locked channel drops valid mid-burst: output stalls, ch4 is never granted
    step();
    ld(3, 0, 1'b0);
    ld(4, 0, 1'b1);
    expb(3, 0, 1'b0);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("stall out_valid", 64'(bus.out_valid), 64'd0);
      chk("stall in_ready",  64'(bus.in_ready),  64'd0);
      step();
    end
    ld(3, 1, 1'b1);
    expb(3, 1, 1'b1);
    expb(4, 0, 1'b1);
    wait_drain(40);

    // Backpressure on ch7, then drain and load on the same edge
    step();
    chk("bp idle out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    ld(7, 0, 1'b1);
    ld(7, 1, 1'b1);
    expb(7, 0, 1'b1);
    expb(7, 1, 1'b1);
    step();
    chk("bp latency out_valid", 64'(bus.out_valid), 64'd1);
    held = pat(7, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp out_sel",   64'(bus.out_sel),   64'd7);
      chk("bp out_data",  64'(bus.out_data),  64'(held));
      chk("bp in_ready",  64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp reload out_valid", 64'(bus.out_valid), 64'd1);
    chk("bp reload out_data",  64'(bus.out_data),  64'(pat(7, 1)));
    wait_drain(20);

    // Reset mid-burst with a held beat and an active lock
    step();
    bus.out_ready = 1'b0;
    ld(1, 0, 1'b0);
    ld(1, 1, 1'b1);
    step();
    chk("pre-rst out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("async rst in_ready",  64'(bus.in_ready),  64'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.mode = 1'b1;
    for (int ch = 0; ch < N; ch++) ld(ch, 0, 1'b1);
    for (int ch = 0; ch < N; ch++) expb(ch, 0, 1'b1);
    wait_drain(60);

    // Parameter sweep: N=2/WIDTH=8 and N=5/WIDTH=64 round-robin streams
    step();
    for (int i = 0; i < 2; i++) s2.in_data[i*8 +: 8] = 8'(i * 17);
    for (int i = 0; i < 5; i++) s5.in_data[i*64 +: 64] = 64'(i) * 64'h0101_0101_0101_0101;
    s2.in_last = '1; s5.in_last = '1;
    s2.in_valid = '1; s5.in_valid = '1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("n2 out_valid", 64'(s2.out_valid), 64'd1);
      chk("n2 out_sel",   64'(s2.out_sel),   64'(k % 2));
      chk("n2 out_data",  64'(s2.out_data),  64'((k % 2) * 17));
      chk("n5 out_sel",   64'(s5.out_sel),   64'(k % 5));
      chk("n5 out_data",  64'(s5.out_data),  64'(k % 5) * 64'h0101_0101_0101_0101);
    end
    s2.in_valid = '0; s5.in_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
